dmem_ctrl: RTL

//  Parametrised data-memory block for the CPU load/store path, successor to the fixed 1K x 32 byte-select RAM.

---
 rtl/dmem_pkg.sv | 26 ++
 rtl/dmem_array.sv | 22 ++
 rtl/dmem_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data-memory controller
// Holds the size encoding, FSM states, byte-lane mask and load-extension helpers,
// and the DATA_W legality check used at elaboration.
package dmem_pkg;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;
  typedef enum logic {CLEAR, RUN} state_e;
  function automatic bit data_w_ok(int w);
    return w == 32 || w == 64;
  endfunction
  // SZ_D means the full word, so on a 32-bit build it is the same as SZ_W
  function automatic int size_bytes(size_e s, int nb);
    return s == SZ_B ? 1 : s == SZ_H ? 2 : s == SZ_W ? 4 : nb;
  endfunction
  function automatic logic [7:0] lane_mask(size_e s, logic [2:0] off, int nb);
    logic [8:0] t;
    t = (9'd1 << size_bytes(s, nb)) - 9'd1;
    return t[7:0] << off;
  endfunction
  function automatic logic [63:0] extend(logic [63:0] d, size_e s, logic uns, int nb);
    int sb;
    sb = size_bytes(s, nb);
    return sb == 1 ? {{56{~uns & d[7]}}, d[7:0]} :
           sb == 2 ? {{48{~uns & d[15]}}, d[15:0]} :
           sb == 4 ? {{32{~uns & d[31]}}, d[31:0]} : d;
  endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x DATA_W single-port synchronous RAM with per-byte write enables
// Ports: clk; idx word index; be byte write enables; wdata lane-aligned write data;
// rdata registered read of idx (old contents on a same-cycle write). Contents are not reset.
module dmem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 1024,
  localparam int NB = DATA_W / 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic [IDX_W-1:0]  idx,
  input  logic [NB-1:0]     be,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++)
      if (be[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
    rdata <= mem[idx];
  end
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte-addressed load/store data memory with post-reset zero-fill sweep
// Ports: clk; rst (async, active-low); req_valid/req_ready handshake; req_we store/load;
// req_size byte/half/32-bit/full; req_unsigned zero-extend loads; req_addr byte address;
// req_wdata right-justified store data; rsp_valid one-cycle response pulse; rsp_rdata
// extended load data (0 for stores); rsp_err misalignment flag; busy during clear sweep.
// Macro DMEM_MISALIGN_EN: misaligned accesses are rejected with rsp_err instead of
// being silently aligned down.
module dmem_ctrl import dmem_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 1024,
  localparam int ADDR_W = $clog2(DEPTH) + $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);
  localparam int NB = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);
`ifdef DMEM_MISALIGN_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif
  if (!data_w_ok(DATA_W)) begin : g_bad_data_w
    $error("dmem_ctrl: DATA_W must be 32 or 64");
  end
  state_e            state;
  logic [IDX_W-1:0]  clr_idx;
  size_e             size, p_size;
  logic [OFF_W-1:0]  off, amask, off_eff, p_off;
  logic              mis, acc, p_we, p_uns, p_err;
  logic [IDX_W-1:0]  a_idx;
  logic [NB-1:0]     a_be;
  logic [DATA_W-1:0] a_wd, a_q;
  assign size    = size_e'(req_size);
  assign amask   = OFF_W'(size_bytes(size, NB) - 1);
  assign off     = req_addr[OFF_W-1:0];
  assign mis     = MIS_EN && |(off & amask);
  assign off_eff = MIS_EN ? off : off & ~amask;
  assign acc     = req_valid && req_ready;
  // The sweep owns the single array port until RUN; requests are held off by req_ready
  assign a_idx = state == CLEAR ? clr_idx : req_addr[ADDR_W-1:OFF_W];
  assign a_be  = state == CLEAR ? '1 :
                 (acc && req_we && !mis) ? NB'(lane_mask(size, 3'(off_eff), NB)) : '0;
  assign a_wd  = state == CLEAR ? '0 : req_wdata << {off_eff, 3'b000};
  dmem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .idx   (a_idx),
    .be    (a_be),
    .wdata (a_wd),
    .rdata (a_q)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= CLEAR;
      clr_idx   <= '0;
      req_ready <= 1'b0;
      busy      <= 1'b1;
    end else if (state == CLEAR) begin
      clr_idx <= clr_idx + 1'b1;
      if (clr_idx == IDX_W'(DEPTH - 1)) begin
        state     <= RUN;
        req_ready <= 1'b1;
        busy      <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= 1'b0;
      p_we      <= 1'b0;
      p_uns     <= 1'b0;
      p_err     <= 1'b0;
      p_off     <= '0;
      p_size    <= SZ_B;
    end else begin
      rsp_valid <= acc;
      if (acc) begin
        p_we   <= req_we;
        p_uns  <= req_unsigned;
        p_err  <= mis;
        p_off  <= off_eff;
        p_size <= size;
      end
    end
  end
  // Array read data arrives the cycle after accept; lane shift and extension happen here
  assign rsp_rdata = (rsp_valid && !p_we && !p_err) ?
                     DATA_W'(extend(64'(a_q >> {p_off, 3'b000}), p_size, p_uns, NB)) : '0;
  assign rsp_err   = rsp_valid && p_err;
endmodule
